// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-sequencer bus: instruction-memory request/response, decode handoff,
// redirect input and flush/trap/count status.
interface pc_fetch_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             imem_req_valid;
  logic [31:0]      imem_req_addr;
  logic             imem_req_ready;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_data;
  logic             if_valid;
  logic [31:0]      if_pc;
  logic [31:0]      if_instr;
  logic             if_ready;
  logic             redirect_valid;
  logic [31:0]      redirect_target;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             misalign_trap;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output if_valid, if_pc, if_instr,
    input  if_ready, redirect_valid, redirect_target,
    output flush_if_id, flush_id_ex, misalign_trap, redirect_count
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  if_valid, if_pc, if_instr,
    output if_ready, redirect_valid, redirect_target,
    input  flush_if_id, flush_id_ex, misalign_trap, redirect_count
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer
// with redirect handling, misaligned-target trapping and flush generation.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned CNT_W        = 16
) (
  input logic                  clk,
  input logic                  rst,
  pc_fetch_sequencer_if.master bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StHold = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             kill_q, kill_d;
  logic [31:0]      pend_q, pend_d;
  logic [31:0]      ipc_q, ipc_d;
  logic [31:0]      instr_q, instr_d;
  logic             flush_q;
  logic             trap_q;
  logic [CNT_W-1:0] count_q;

  logic        misaligned;
  logic [31:0] eff_target;

  assign misaligned = bus.redirect_target[1:0] != 2'b00;
  assign eff_target = misaligned ? TRAP_VECTOR : bus.redirect_target;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    pend_d  = pend_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    case (state_q)
      StIdle: begin
        state_d = StReq;
        if (bus.redirect_valid) pc_d = eff_target;
      end
      StReq: begin
        // The request is never withdrawn; a redirect only marks it for discard.
        if (bus.imem_req_ready) state_d = StWait;
        if (bus.redirect_valid) begin
          kill_d = 1'b1;
          pend_d = eff_target;
        end
      end
      StWait: begin
        if (bus.redirect_valid) begin
          if (bus.imem_rsp_valid) begin
            pc_d    = eff_target;
            kill_d  = 1'b0;
            state_d = StReq;
          end else begin
            kill_d = 1'b1;
            pend_d = eff_target;
          end
        end else if (bus.imem_rsp_valid) begin
          if (kill_q) begin
            pc_d    = pend_q;
            kill_d  = 1'b0;
            state_d = StReq;
          end else begin
            instr_d = bus.imem_rsp_data;
            ipc_d   = pc_q;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (bus.redirect_valid) begin
          pc_d    = eff_target;
          state_d = StReq;
        end else if (bus.if_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_VECTOR;
      kill_q  <= 1'b0;
      pend_q  <= 32'h0;
      ipc_q   <= 32'h0;
      instr_q <= 32'h0;
      flush_q <= 1'b0;
      trap_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      pend_q  <= pend_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      flush_q <= bus.redirect_valid;
      trap_q  <= bus.redirect_valid & misaligned;
      if (bus.redirect_valid) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.imem_req_valid = state_q == StReq;
  assign bus.imem_req_addr  = (state_q == StReq) ? pc_q : 32'h0;
  assign bus.if_valid       = state_q == StHold;
  assign bus.if_pc          = ipc_q;
  assign bus.if_instr       = instr_q;
  assign bus.flush_if_id    = flush_q;
  assign bus.flush_id_ex    = flush_q;
  assign bus.misalign_trap  = trap_q;
  assign bus.redirect_count = count_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction model.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] ResetVec = 32'h0000_0000;
  localparam logic [31:0] TrapVec  = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_sequencer_if #(.CNT_W(16)) bus ();

  pc_fetch_sequencer #(
    .RESET_VECTOR(ResetVec),
    .TRAP_VECTOR (TrapVec),
    .CNT_W       (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: which phase of a fetch is active, plus the redirect bookkeeping.
  bit          m_boot, m_req, m_wait, m_hold, m_discard;
  logic [31:0] m_pc, m_next, m_ipc, m_instr;
  bit          m_flush, m_trap;
  logic [15:0] m_count;
  bit          mem_out;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_req = 0; m_wait = 0; m_hold = 0; m_discard = 0;
    m_pc = ResetVec; m_next = 0; m_ipc = 0; m_instr = 0;
    m_flush = 0; m_trap = 0; m_count = 0; mem_out = 0;
  endtask

  task automatic model_step(input bit rdy, input bit rv, input logic [31:0] rd,
                            input bit ir, input bit rdv, input logic [31:0] tgt);
    logic [31:0] dest;
    bit          bad;
    bad  = tgt[1:0] != 2'b00;
    dest = bad ? TrapVec : tgt;
    m_flush = rdv;
    m_trap  = rdv && bad;
    if (rdv) m_count = m_count + 16'd1;
    if (m_boot) begin
      m_boot = 0; m_req = 1;
      if (rdv) m_pc = dest;
    end else if (m_req) begin
      if (rdv) begin m_discard = 1; m_next = dest; end
      if (rdy) begin m_req = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (rv) begin
        m_wait = 0;
        if (rdv) begin m_pc = dest; m_discard = 0; m_req = 1; end
        else if (m_discard) begin m_pc = m_next; m_discard = 0; m_req = 1; end
        else begin m_ipc = m_pc; m_instr = rd; m_hold = 1; end
      end else if (rdv) begin
        m_discard = 1; m_next = dest;
      end
    end else if (m_hold) begin
      if (rdv || ir) begin
        m_hold = 0; m_req = 1;
        m_pc = rdv ? dest : m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_all();
    chk("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, m_req});
    if (m_req) chk("req_addr", bus.imem_req_addr, m_pc);
    chk("if_valid", {31'b0, bus.if_valid}, {31'b0, m_hold});
    if (m_hold) begin
      chk("if_pc", bus.if_pc, m_ipc);
      chk("if_instr", bus.if_instr, m_instr);
    end
    chk("flush_if_id", {31'b0, bus.flush_if_id}, {31'b0, m_flush});
    chk("flush_id_ex", {31'b0, bus.flush_id_ex}, {31'b0, m_flush});
    chk("misalign_trap", {31'b0, bus.misalign_trap}, {31'b0, m_trap});
    chk("redirect_count", {16'b0, bus.redirect_count}, {16'b0, m_count});
  endtask

  // One clock: check state, drive inputs, advance model, step to just past the edge.
  task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rd,
                       input bit ir, input bit rdv, input logic [31:0] tgt);
    compare_all();
    bus.imem_req_ready  = rdy;
    bus.imem_rsp_valid  = rv;
    bus.imem_rsp_data   = rd;
    bus.if_ready        = ir;
    bus.redirect_valid  = rdv;
    bus.redirect_target = tgt;
    model_step(rdy, rv, rd, ir, rdv, tgt);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    cycle(0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, {31'b0, bus.imem_req_valid}, 32'h0);
    chk({tag, "_req_addr"}, bus.imem_req_addr, 32'h0);
    chk({tag, "_if_valid"}, {31'b0, bus.if_valid}, 32'h0);
    chk({tag, "_if_pc"}, bus.if_pc, 32'h0);
    chk({tag, "_if_instr"}, bus.if_instr, 32'h0);
    chk({tag, "_flush"}, {31'b0, bus.flush_if_id}, 32'h0);
    chk({tag, "_trap"}, {31'b0, bus.misalign_trap}, 32'h0);
    chk({tag, "_count"}, {16'b0, bus.redirect_count}, 32'h0);
  endtask

  initial begin
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0;
    bus.if_ready = 0; bus.redirect_valid = 0; bus.redirect_target = 0;
    model_reset();
    #3;
    check_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // Straight-line fetch: 0x0, 0x4, 0x8
    idle_cycle();
    chk("first_addr", bus.imem_req_addr, 32'h0);
    chk("first_valid", {31'b0, bus.imem_req_valid}, 32'h1);
    for (int k = 0; k < 2; k++) begin
      cycle(1, 0, 32'h0, 0, 0, 32'h0);
      cycle(0, 1, 32'h1111_0000 + k, 0, 0, 32'h0);
      chk("seq_if_pc", bus.if_pc, 32'(k * 4));
      chk("seq_if_instr", bus.if_instr, 32'h1111_0000 + k);
      cycle(0, 0, 32'h0, 1, 0, 32'h0);
      chk("seq_next_addr", bus.imem_req_addr, 32'(k * 4 + 4));
    end

    // Redirect in WAIT; stale 0xDEADBEEF must be discarded
    cycle(1, 0, 32'h0, 1, 0, 32'h0);
    cycle(0, 0, 32'h0, 1, 1, 32'h200);
    chk("t2_flush", {31'b0, bus.flush_if_id}, 32'h1);
    chk("t2_count", {16'b0, bus.redirect_count}, 32'h1);
    idle_cycle();
    chk("t2_flush_off", {31'b0, bus.flush_id_ex}, 32'h0);
    cycle(0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0);
    chk("t2_no_present", {31'b0, bus.if_valid}, 32'h0);
    chk("t2_addr", bus.imem_req_addr, 32'h200);

    // Redirect in HOLD without if_ready
    cycle(1, 0, 32'h0, 0, 0, 32'h0);
    cycle(0, 1, 32'h0BAD_0001, 0, 0, 32'h0);
    chk("t3_hold", {31'b0, bus.if_valid}, 32'h1);
    cycle(0, 0, 32'h0, 0, 1, 32'h300);
    chk("t3_drop", {31'b0, bus.if_valid}, 32'h0);
    chk("t3_addr", bus.imem_req_addr, 32'h300);

    // Misaligned redirect goes to the trap vector
    cycle(1, 0, 32'h0, 0, 0, 32'h0);
    cycle(0, 1, 32'h0BAD_0002, 0, 0, 32'h0);
    cycle(0, 0, 32'h0, 0, 1, 32'h402);
    chk("t4_trap", {31'b0, bus.misalign_trap}, 32'h1);
    chk("t4_addr", bus.imem_req_addr, 32'h100);
    idle_cycle();
    chk("t4_trap_off", {31'b0, bus.misalign_trap}, 32'h0);

    // Back-to-back redirects in WAIT: latest wins
    cycle(1, 0, 32'h0, 0, 0, 32'h0);
    cycle(0, 0, 32'h0, 0, 1, 32'h500);
    chk("t5_flush_a", {31'b0, bus.flush_if_id}, 32'h1);
    cycle(0, 0, 32'h0, 0, 1, 32'h600);
    chk("t5_flush_b", {31'b0, bus.flush_if_id}, 32'h1);
    chk("t5_count", {16'b0, bus.redirect_count}, 32'd5);
    cycle(0, 1, 32'h0BAD_0003, 0, 0, 32'h0);
    chk("t5_addr", bus.imem_req_addr, 32'h600);

    // Reset while WAIT; stale response in IDLE and REQ is ignored
    cycle(1, 0, 32'h0, 0, 0, 32'h0);
    rst = 1;
    #2;
    model_reset();
    check_reset_outputs("rst1");
    @(posedge clk);
    #1;
    rst = 0;
    cycle(0, 1, 32'h0BAD_0004, 0, 0, 32'h0);
    cycle(0, 1, 32'h0BAD_0005, 0, 0, 32'h0);
    chk("t6_addr", bus.imem_req_addr, ResetVec);
    chk("t6_valid", {31'b0, bus.imem_req_valid}, 32'h1);
    chk("t6_hold", {31'b0, bus.if_valid}, 32'h0);

    // PC wrap at 0xFFFF_FFFC, redirect raised while REQ is stalled
    cycle(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC);
    chk("t7_stable", bus.imem_req_addr, 32'h0);
    cycle(1, 0, 32'h0, 0, 0, 32'h0);
    cycle(0, 1, 32'h0BAD_0006, 0, 0, 32'h0);
    chk("t7_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    cycle(1, 0, 32'h0, 0, 0, 32'h0);
    cycle(0, 1, 32'hCAFE_F00D, 0, 0, 32'h0);
    chk("t7_if_pc", bus.if_pc, 32'hFFFF_FFFC);
    cycle(0, 0, 32'h0, 1, 0, 32'h0);
    chk("t7_wrap", bus.imem_req_addr, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit          rdy, rv, ir, rdv, accept, deliver;
      logic [31:0] rd, tgt;
      rdy = ($urandom % 2) == 0;
      rv  = mem_out ? (($urandom % 3) == 0) : (($urandom % 16) == 0);
      rd  = $urandom;
      ir  = ($urandom % 2) == 0;
      rdv = ($urandom % 10) == 0;
      tgt = {$urandom_range(0, 15), 2'b00} << 2;
      if (($urandom % 4) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      if (($urandom % 50) == 0) tgt = 32'hFFFF_FFFC;
      accept  = m_req && rdy;
      deliver = mem_out && rv;
      cycle(rdy, rv, rd, ir, rdv, tgt);
      if (deliver) mem_out = 0;
      if (accept) mem_out = 1;
    end
    compare_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the CPU front end.
- Issues one-outstanding fetches to instruction memory over a valid/ready handshake and presents fetched instructions to decode.
- Accepts redirects from the jump/branch resolution stage and emits pipeline flush pulses.
- Replaces misaligned redirect targets with a trap vector and counts redirects.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset
TRAP_VECTOR, 32'h0000_0100, substitute target for misaligned redirects
CNT_W, 16, width of redirect counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  32  fetch address
imem_req_ready  in  1  memory accepts request
imem_rsp_valid  in  1  fetch data valid
imem_rsp_data  in  32  fetched instruction
if_valid  out  1  instruction available to decode
if_pc  out  32  PC of presented instruction
if_instr  out  32  presented instruction
if_ready  in  1  decode accepts instruction
redirect_valid  in  1  single-cycle redirect request from branch stage
redirect_target  in  32  new PC
flush_if_id  out  1  one-cycle flush pulse
flush_id_ex  out  1  one-cycle flush pulse
misalign_trap  out  1  one-cycle pulse, misaligned target replaced
redirect_count  out  CNT_W  number of redirects taken, wraps

Behaviour:
- Reset (async, any state):
  - state=IDLE, pc=RESET_VECTOR, kill=0.
  - All outputs 0, redirect_count=0.
  - Any response arriving after reset is ignored unless state is WAIT.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE -> REQ unconditionally, one cycle after reset release.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - Address is held stable until imem_req_ready=1.
  - On ready -> WAIT.
- WAIT:
  - On imem_rsp_valid with kill=0: latch data into if_instr, if_pc=pc -> HOLD.
  - On imem_rsp_valid with kill=1: discard data, pc=pending target, kill=0 -> REQ.
- HOLD:
  - if_valid=1.
  - On if_ready: pc=pc+4 (mod 2^32, wraps) -> REQ.
  - if_valid drops the next cycle.
- Redirect (redirect_valid=1) has highest priority.
  - Effective target = redirect_target, or TRAP_VECTOR if redirect_target[1:0]!=0.
  - IDLE: pc=effective target; stays on the normal IDLE -> REQ path.
  - REQ, not accepted this cycle: the request stays stable (no withdrawal); kill=1, pending=target. Response is later discarded.
  - REQ, accepted same cycle: -> WAIT with kill=1.
  - WAIT: kill=1, pending=target. Redirect coincident with rsp_valid: response discarded, -> REQ at target next cycle.
  - HOLD: held instruction dropped, if_valid=0 next cycle, pc=target -> REQ. Coincident with if_ready: the handshake completes, but no pc+4 is applied; the target wins.
  - A second redirect while kill=1 overwrites pending; the latest redirect wins.
- Flush outputs:
  - flush_if_id and flush_id_ex are registered: both pulse 1 for exactly one cycle, the cycle after redirect_valid.
  - Back-to-back redirects give back-to-back pulses.
- misalign_trap pulses the cycle after a misaligned redirect.
- redirect_count increments the cycle after each redirect; wraps at 2^CNT_W.
- Latency: redirect to new-target imem_req_valid is 1 cycle from HOLD, IDLE or a coincident response; otherwise it waits for the outstanding response.
- Maximum one outstanding request. Peak throughput is one instruction per 3 cycles with ready/rsp single-cycle.

Test Plan:
- Reset release, imem ready always, response 1 cycle after accept, if_ready=1 -> addresses 0x0, 0x4, 0x8 issued in order; if_pc matches; all outputs 0 during reset.
- Redirect to 0x200 while in WAIT; response 0xDEADBEEF arrives 2 cycles later -> 0xDEADBEEF never presented; next request addr 0x200; flush pulses once; redirect_count=1.
- Redirect to 0x300 while in HOLD with if_ready=0 -> if_valid drops next cycle; next req addr 0x300.
- Redirect target 0x402 -> misalign_trap pulses once; next req addr 0x100.
- Two redirects (0x500, then 0x600 the next cycle) while in WAIT -> only 0x600 fetched; two flush pulses; redirect_count=2.
- Assert rst during WAIT, then release; a stale response arrives in REQ -> ignored; first req addr RESET_VECTOR.
- Run to pc 0xFFFF_FFFC and accept -> next addr 0x0000_0000.
